// File: rtl/seq_alu.sv
// seq_alu: multi-cycle EX-stage ALU. Logic/arith/shift/compare ops take one cycle; MUL (shift-add) and DIV (restoring) iterate WIDTH cycles.
// Optional macro SEQ_ALU_HI_RESULT_EN drives ALU_result_hi with the high product half / remainder; otherwise it is tied to 0.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ALU_start,
  input  logic [3:0]               ALU_control,
  input  logic [WIDTH-1:0]         ALU_operand_1,
  input  logic [WIDTH-1:0]         ALU_operand_2,
  input  logic [$clog2(WIDTH)-1:0] ALU_shamt,
  output logic                     ALU_busy,
  output logic                     ALU_done,
  output logic [WIDTH-1:0]         ALU_result,
  output logic [WIDTH-1:0]         ALU_result_hi,
  output logic [7:0]               ALU_status
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b1111;

  // Handshake: ALU_start is accepted whenever ALU_busy=0 (IDLE or DONE); ALU_done pulses
  // for one cycle exactly when result/result_hi/status update. There is no backpressure.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             accept, launch_mul, launch_div, launch_iter, iterating, iter_last;

  assign accept      = ALU_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign launch_mul  = (ALU_control == OP_MUL);
  assign launch_div  = (ALU_control == OP_DIV) && (ALU_operand_2 != '0);
  assign launch_iter = launch_mul || launch_div;
  assign iterating   = (state_q == S_MUL) || (state_q == S_DIV);
  assign iter_last   = iterating && (cnt_q == '0);

  function automatic logic [7:0] flags(input logic [WIDTH-1:0] r, input logic ovf,
                                       input logic cy, input logic dz);
    return {r == '0, ovf, cy, r[WIDTH-1], r[1] | r[0], dz, 2'b00};
  endfunction

  // Single-cycle datapath; shifts act on operand 1.
  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH-1:0] sc_res;
  logic [7:0]       sc_status;
  logic             sc_carry, sc_ovf, sc_divz, sc_known;

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_divz  = 1'b0;
    sc_known = 1'b1;
    add_sum  = {1'b0, ALU_operand_1} + {1'b0, ALU_operand_2};
    sub_diff = {1'b0, ALU_operand_1} - {1'b0, ALU_operand_2};
    case (ALU_control)
      OP_AND: sc_res = ALU_operand_1 & ALU_operand_2;
      OP_OR:  sc_res = ALU_operand_1 | ALU_operand_2;
      OP_NOR: sc_res = ~(ALU_operand_1 | ALU_operand_2);
      OP_SLL: sc_res = ALU_operand_1 << ALU_shamt;
      OP_SRL: sc_res = ALU_operand_1 >> ALU_shamt;
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
      OP_ADD: begin
        sc_res   = add_sum[WIDTH-1:0];
        sc_carry = add_sum[WIDTH];
        sc_ovf   = (ALU_operand_1[WIDTH-1] == ALU_operand_2[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != ALU_operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_diff[WIDTH-1:0];
        sc_carry = sub_diff[WIDTH];
        sc_ovf   = (ALU_operand_1[WIDTH-1] != ALU_operand_2[WIDTH-1]) &&
                   (sub_diff[WIDTH-1] != ALU_operand_1[WIDTH-1]);
      end
      // Only divide-by-zero completes here; a non-zero divisor takes the iterative path.
      OP_DIV: begin
        sc_res  = '1;
        sc_divz = 1'b1;
      end
      default: sc_known = 1'b0;
    endcase
    sc_status = sc_known ? flags(sc_res, sc_ovf, sc_carry, sc_divz) : 8'h00;
  end

  // One iteration step: MUL shifts {acc_hi,acc_lo} right after a conditional add;
  // DIV shifts left and keeps the trial subtraction when it does not go negative.
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (state_q == S_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!ALU_start)      state_d = S_IDLE;
        else if (launch_mul) state_d = S_MUL;
        else if (launch_div) state_d = S_DIV;
        else                 state_d = S_DONE;
      end
      S_MUL, S_DIV: if (cnt_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ALU_busy = iterating;
    ALU_done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      ALU_result <= '0;
      ALU_status <= '0;
    end else if (accept) begin
      if (launch_mul) begin
        opnd_q   <= ALU_operand_1;
        acc_lo_q <= ALU_operand_2;
        acc_hi_q <= '0;
        cnt_q    <= CNT_W'(WIDTH - 1);
      end else if (launch_div) begin
        opnd_q   <= ALU_operand_2;
        acc_lo_q <= ALU_operand_1;
        acc_hi_q <= '0;
        cnt_q    <= CNT_W'(WIDTH - 1);
      end else begin
        ALU_result <= sc_res;
        ALU_status <= sc_status;
      end
    end else if (iterating) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (iter_last) begin
        ALU_result <= step_lo;
        ALU_status <= flags(step_lo, 1'b0, 1'b0, 1'b0);
      end
    end
  end

`ifdef SEQ_ALU_HI_RESULT_EN
  logic [WIDTH-1:0] result_hi_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                    result_hi_q <= '0;
    else if (accept && !launch_iter) result_hi_q <= (ALU_control == OP_DIV) ? ALU_operand_1 : '0;
    else if (iter_last)              result_hi_q <= step_hi;
  end

  assign ALU_result_hi = result_hi_q;
`else
  assign ALU_result_hi = '0;
`endif

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the datapath's single-cycle combinational ALU; sits in the EX stage of the multi-cycle core.
- Logic/arith/shift/compare ops complete in 1 cycle. MUL (shift-add) and DIV (restoring) are iterative over WIDTH cycles.
- Start/busy/done handshake; status byte keeps the existing 8-bit flag layout.

Parameters:
- WIDTH, 32, operand/result width (>=8, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  single rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- ALU_start  in  1  request; sampled only when ALU_busy=0.
- ALU_control  in  4  opcode: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (unsigned), 1100 nor, 1110 sll, 1111 srl, 0011 mul, 0100 div.
- ALU_operand_1  in  WIDTH  operand A.
- ALU_operand_2  in  WIDTH  operand B.
- ALU_shamt  in  $clog2(WIDTH)  shift amount.
- ALU_busy  out  1  operation in progress.
- ALU_done  out  1  one-cycle pulse; result/status valid.
- ALU_result  out  WIDTH  registered result; low WIDTH bits of product, quotient for div.
- ALU_result_hi  out  WIDTH  high product half / remainder (see Optional Feature).
- ALU_status  out  8  {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE. busy=0, done=0, result=0, result_hi=0, status=0. Reset mid-operation aborts it; no done pulse.
- States:
  - IDLE: start=1 latches opcode and operands. Single-cycle op -> DONE, with result and status registered that edge. mul -> MUL. div with B!=0 -> DIV. div with B=0 -> DONE.
  - MUL: one shift-add step per cycle; counter runs WIDTH-1 down to 0; leaves to DONE on the cycle it reaches 0.
  - DIV: one restoring step per cycle, same counter, then DONE.
  - DONE: done=1 for exactly one cycle. Acts as IDLE: start=1 here launches the next op back-to-back; otherwise -> IDLE.
- busy=1 in MUL and DIV only. start during busy is ignored, with no effect on the operation.
- Latency (start edge = cycle 0, done high in cycle N):
  - single-cycle ops: N=1.
  - mul and div: N=WIDTH+1.
  - div by zero: N=1.
- Operands are captured at start. Input changes afterwards have no effect.
- result/result_hi/status hold their value until the next op completes.
- Arithmetic:
  - add: carry = unsigned carry-out; overflow = signed overflow.
  - sub: carry = unsigned borrow (A<B unsigned); overflow = signed overflow.
  - All other ops: carry=0, overflow=0.
  - mul: unsigned 2*WIDTH product.
  - div: unsigned; div_zero=1, quotient all ones, remainder = A.
  - Shifts are logical; shamt covers 0..WIDTH-1.
- Flags:
  - zero = (result==0).
  - negative = result[WIDTH-1].
  - invalid_address = result[1]|result[0].
  - div_zero is set only for div with B=0.
- Undefined opcode: completes in 1 cycle with result=0, result_hi=0, status=0.

Optional Feature:
- Macro SEQ_ALU_HI_RESULT_EN.
- Defined: ALU_result_hi = product[2*WIDTH-1:WIDTH] for mul, remainder for div, 0 for all other ops.
- Undefined: ALU_result_hi tied to 0, and the hi-half/remainder storage is not synthesised. The mul datapath still needs the full accumulator internally. ALU_result is identical in both builds.

Test Plan:
- Reset mid-MUL (reset_n=0 in cycle 5, WIDTH=32) -> busy=0, done never pulses, result=0, status=0.
- add 0x7FFFFFFF+0x00000001 -> cycle 1: done=1, result=0x80000000, status=8'b0101_0000 (overflow, negative).
- sub 0x00000003-0x00000005 -> result=0xFFFFFFFE, carry=1, negative=1, overflow=0, invalid_address=1.
- mul 0x00010000*0x00010000 -> busy cycles 1..32, done cycle 33, result=0, zero=1; with SEQ_ALU_HI_RESULT_EN, result_hi=0x00000001.
- div 100/7 -> done cycle 33, result=14, result_hi=2 (with EN). div 5/0 -> done cycle 1, result=0xFFFFFFFF, div_zero=1.
- start held high through a 33-cycle mul, then and 0xF0 & 0x3C issued in the DONE cycle -> mul done pulse, next cycle done with result=0x30. start during busy ignored.
